// File: rtl/gnn_pkg.sv
// gnn_pkg: shared constants, types and helpers for the GNN node sequencer
package gnn_pkg;
    localparam int ACC_W = 17;
    localparam int NODE_W = 4;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} seq_state_t;
    typedef struct packed {
        logic [NODE_W-1:0]       node;
        logic signed [ACC_W-1:0] r0;
        logic signed [ACC_W-1:0] r1;
    } res_entry_t;
    function automatic int cred_w(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/gnn_result_fifo.sv
// gnn_result_fifo: synchronous FIFO holding tagged mac_node results
module gnn_result_fifo import gnn_pkg::*; #(
    parameter int W = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic [cred_w(DEPTH)-1:0] count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = cred_w(DEPTH);
    logic [W-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic do_push, do_pop;
    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction
    always_comb begin
        do_pop = pop && !empty;
        do_push = push && (!full || do_pop);
        wr_d = do_push ? inc(wr_q) : wr_q;
        rd_d = do_pop ? inc(rd_q) : rd_q;
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            cnt_q <= cnt_d;
        end
    end
    always_ff @(posedge clk)
        if (do_push) mem_q[wr_q] <= din;
    assign dout = mem_q[rd_q];
    assign count = cnt_q;
    assign full = cnt_q == CW'(DEPTH);
    assign empty = cnt_q == '0;
endmodule

// File: rtl/gnn_node_sequencer.sv
// gnn_node_sequencer: feeds buffered node features to mac_node and collects tagged results
module gnn_node_sequencer #(
    parameter int IN_SIZE = 5,
    parameter int NUM_NODES = 16,
    parameter int RES_DEPTH = 4,
    parameter int ACC_W = gnn_pkg::ACC_W,
    localparam int NW = $clog2(NUM_NODES)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ld_valid,
    input  logic [NW-1:0]             ld_addr,
    input  logic [4*IN_SIZE-1:0]      ld_data,
    input  logic                      start,
    input  logic [NW:0]               node_count,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic signed [IN_SIZE-1:0] x0,
    output logic signed [IN_SIZE-1:0] x1,
    output logic signed [IN_SIZE-1:0] x2,
    output logic signed [IN_SIZE-1:0] x3,
    output logic                      in_ready,
    input  logic signed [ACC_W-1:0]   out0,
    input  logic signed [ACC_W-1:0]   out1,
    input  logic                      out0_ready,
    input  logic                      out1_ready,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [NW-1:0]             res_node,
    output logic signed [ACC_W-1:0]   res0,
    output logic signed [ACC_W-1:0]   res1
);
    import gnn_pkg::*;
    localparam int CW = cred_w(RES_DEPTH);
    localparam logic [NW:0] MAXN = (NW + 1)'(NUM_NODES);
    typedef struct packed {
        logic [NW-1:0]           node;
        logic signed [ACC_W-1:0] r0;
        logic signed [ACC_W-1:0] r1;
    } entry_t;
    seq_state_t state_q, state_d;
    logic [NW:0] cnt_q, cnt_d, iss_q, iss_d, cap_q, cap_d;
    logic [CW-1:0] infl_q, infl_d, fifo_cnt;
    logic [4*IN_SIZE-1:0] feat_q [NUM_NODES];
    logic [4*IN_SIZE-1:0] x_q, x_d;
    logic in_rdy_q, in_rdy_d, err_q, err_d;
    logic active, issue, capture, fifo_full, fifo_empty;
    entry_t push_e, head_e;
    always_ff @(posedge clk)
        if (state_q == IDLE && ld_valid && {1'b0, ld_addr} < MAXN) feat_q[ld_addr] <= ld_data;
    // results already queued plus those still inside mac_node must fit in the FIFO
    always_comb begin
        active = state_q == RUN || state_q == DRAIN;
        issue = state_q == RUN && ({1'b0, fifo_cnt} + {1'b0, infl_q}) < (CW + 1)'(RES_DEPTH);
        capture = active && out0_ready && out1_ready && infl_q != '0;
        state_d = state_q;
        cnt_d = cnt_q;
        iss_d = issue ? iss_q + 1'b1 : iss_q;
        cap_d = capture ? cap_q + 1'b1 : cap_q;
        infl_d = infl_q + CW'(issue) - CW'(capture);
        x_d = issue ? feat_q[NW'(iss_q)] : x_q;
        in_rdy_d = issue;
        err_d = err_q || (active && (out0_ready != out1_ready || (out0_ready && infl_q == '0)));
        case (state_q)
            IDLE: if (start) begin
                state_d = node_count == '0 ? DONE : RUN;
                cnt_d = node_count > MAXN ? MAXN : node_count;
                iss_d = '0;
                cap_d = '0;
                err_d = err_q || node_count > MAXN;
            end
            RUN: if (issue && iss_q == cnt_q - 1'b1) state_d = DRAIN;
            DRAIN: if (infl_q == '0 && cap_q == cnt_q) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            iss_q <= '0;
            cap_q <= '0;
            infl_q <= '0;
            x_q <= '0;
            in_rdy_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            iss_q <= iss_d;
            cap_q <= cap_d;
            infl_q <= infl_d;
            x_q <= x_d;
            in_rdy_q <= in_rdy_d;
            err_q <= err_d;
        end
    end
    assign push_e = {NW'(cap_q), out0, out1};
    gnn_result_fifo #(.W($bits(entry_t)), .DEPTH(RES_DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(capture && (!fifo_full || res_ready)),
        .din(push_e),
        .pop(res_ready),
        .dout(head_e),
        .count(fifo_cnt),
        .full(fifo_full),
        .empty(fifo_empty)
    );
    assign busy = active;
    assign done = state_q == DONE;
    assign err = err_q;
    assign in_ready = in_rdy_q;
    assign x0 = x_q[IN_SIZE-1:0];
    assign x1 = x_q[2*IN_SIZE-1:IN_SIZE];
    assign x2 = x_q[3*IN_SIZE-1:2*IN_SIZE];
    assign x3 = x_q[4*IN_SIZE-1:3*IN_SIZE];
    assign res_valid = !fifo_empty;
    assign res_node = head_e.node;
    assign res0 = head_e.r0;
    assign res1 = head_e.r1;
endmodule

// File: tb/tb_gnn_node_sequencer.sv
// tb_gnn_node_sequencer: directed table-driven bench with a 3-cycle mac_node stub
module tb_gnn_node_sequencer;
    localparam int IN_SIZE = 5, NUM_NODES = 16, RES_DEPTH = 4, ACC_W = 17, NW = 4;
    typedef struct { logic signed [4:0] x0, x1, x2, x3; int r0; int r1; } vec_t;
    typedef struct { int node; int r0; int r1; } res_t;
    logic clk = 0, rst = 1, ld_valid = 0, start = 0, res_ready = 0, g0 = 0;
    logic [NW-1:0] ld_addr = '0;
    logic [4*IN_SIZE-1:0] ld_data = '0;
    logic [NW:0] node_count = '0;
    logic busy, done, err, in_ready, res_valid, out0_ready, out1_ready;
    logic signed [IN_SIZE-1:0] x0, x1, x2, x3;
    logic signed [ACC_W-1:0] out0, out1, res0, res1;
    logic [NW-1:0] res_node;
    logic [2:0] pv = '0;
    logic signed [ACC_W-1:0] ps0 [3];
    logic signed [ACC_W-1:0] ps1 [3];
    vec_t tbl [8];
    res_t got [$];
    int checks = 0, errors = 0, n_iss = 0, n_done = 0, run = 0, max_run = 0;
    int b, i0, d0;

    gnn_node_sequencer #(.IN_SIZE(IN_SIZE), .NUM_NODES(NUM_NODES), .RES_DEPTH(RES_DEPTH), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
        .start(start), .node_count(node_count), .busy(busy), .done(done), .err(err),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3), .in_ready(in_ready),
        .out0(out0), .out1(out1), .out0_ready(out0_ready), .out1_ready(out1_ready),
        .res_valid(res_valid), .res_ready(res_ready), .res_node(res_node), .res0(res0), .res1(res1)
    );

    always #5 clk = ~clk;

    // mac_node stand-in: out0 = x0+x1+x2+x3, out1 = x0, three cycles after in_ready
    always @(posedge clk) begin
        pv <= {pv[1:0], in_ready};
        ps0[0] <= ACC_W'(int'(x0) + int'(x1) + int'(x2) + int'(x3));
        ps1[0] <= ACC_W'(int'(x0));
        ps0[1] <= ps0[0];
        ps1[1] <= ps1[0];
        ps0[2] <= ps0[1];
        ps1[2] <= ps1[1];
    end
    assign out0_ready = pv[2] | g0;
    assign out1_ready = pv[2];
    assign out0 = ps0[2];
    assign out1 = ps1[2];

    always @(negedge clk) begin
        if (in_ready) begin
            n_iss <= n_iss + 1;
            run <= run + 1;
            if (run + 1 > max_run) max_run <= run + 1;
        end else run <= 0;
        if (done) n_done <= n_done + 1;
        if (res_valid && res_ready) got.push_back('{int'(res_node), int'(res0), int'(res1)});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic vec_t mk(input int a, input int bb, input int c, input int d, input int r0, input int r1);
        mk.x0 = 5'(a);
        mk.x1 = 5'(bb);
        mk.x2 = 5'(c);
        mk.x3 = 5'(d);
        mk.r0 = r0;
        mk.r1 = r1;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic go(input int n);
        node_count = (NW + 1)'(n);
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic wait_done(input int base);
        for (int i = 0; i < 200 && n_done == base; i++) tick();
        tick(3);
        chk("done_pulses", n_done - base, 1);
    endtask

    task automatic chk_res(input int base, input int n);
        chk("res_count", got.size() - base, n);
        for (int i = 0; i < n && base + i < got.size(); i++) begin
            chk($sformatf("res_node[%0d]", i), got[base+i].node, i);
            chk($sformatf("res0[%0d]", i), got[base+i].r0, tbl[i].r0);
            chk($sformatf("res1[%0d]", i), got[base+i].r1, tbl[i].r1);
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) tbl[k] = mk(k, -k, 2, -16, -14, k);
        tbl[4] = mk(15, 15, 15, 15, 60, 15);
        tbl[5] = mk(-16, -16, -16, -16, -64, -16);
        tbl[6] = mk(7, -3, 5, 0, 9, 7);
        tbl[7] = mk(-1, -1, 1, 1, 0, -1);

        tick(3);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_x0", x0, 0);
        chk("rst_x3", x3, 0);
        rst = 0;
        for (int k = 0; k < 8; k++) begin
            ld_valid = 1;
            ld_addr = NW'(k);
            ld_data = {tbl[k].x3, tbl[k].x2, tbl[k].x1, tbl[k].x0};
            tick();
        end
        ld_valid = 0;

        // four nodes, consumer always ready
        res_ready = 1;
        b = got.size(); i0 = n_iss; d0 = n_done;
        go(4);
        chk("t1_busy", busy, 1);
        chk("t1_lat0", in_ready, 0);
        tick();
        chk("t1_lat1", in_ready, 1);
        wait_done(d0);
        chk("t1_issues", n_iss - i0, 4);
        chk("t1_back_to_back", max_run, 4);
        chk("t1_err", err, 0);
        chk("t1_busy_end", busy, 0);
        chk("t1_x0_hold", x0, 3);
        chk("t1_x3_hold", x3, -16);
        chk_res(b, 4);

        // eight nodes with a stalled consumer: issue stops at the credit limit
        res_ready = 0;
        b = got.size(); i0 = n_iss; d0 = n_done;
        go(8);
        tick(20);
        chk("t2_stall_issues", n_iss - i0, RES_DEPTH);
        chk("t2_res_valid", res_valid, 1);
        chk("t2_busy", busy, 1);
        res_ready = 1;
        wait_done(d0);
        chk("t2_issues", n_iss - i0, 8);
        chk_res(b, 8);

        // empty pass
        i0 = n_iss; d0 = n_done;
        go(0);
        chk("t3_done", done, 1);
        chk("t3_busy", busy, 0);
        tick();
        chk("t3_done_once", done, 0);
        chk("t3_busy2", busy, 0);
        tick(3);
        chk("t3_issues", n_iss - i0, 0);
        chk("t3_pulses", n_done - d0, 1);

        // mismatched ready flags plus a load attempt while running
        b = got.size(); d0 = n_done;
        go(4);
        tick();
        g0 = 1;
        ld_valid = 1;
        ld_addr = 4'd2;
        ld_data = '1;
        tick();
        g0 = 0;
        ld_valid = 0;
        chk("t4_err", err, 1);
        wait_done(d0);
        chk("t4_err_sticky", err, 1);
        chk_res(b, 4);

        // the ignored load must not have touched node 2
        b = got.size(); d0 = n_done;
        go(4);
        wait_done(d0);
        chk("t5_err_sticky", err, 1);
        chk_res(b, 4);

        // reset two cycles into a pass; stale flags then arrive in IDLE
        b = got.size(); i0 = n_iss; d0 = n_done;
        go(8);
        tick(2);
        rst = 1;
        tick();
        rst = 0;
        chk("t6_in_ready", in_ready, 0);
        chk("t6_res_valid", res_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_err_clear", err, 0);
        tick(8);
        chk("t6_stale_entries", got.size() - b, 0);
        chk("t6_res_valid_late", res_valid, 0);
        chk("t6_err_late", err, 0);
        chk("t6_no_done", n_done - d0, 0);
        chk("t6_issues", n_iss - i0, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
